// File: rtl/sync_pkg.sv
// Shared definitions for the 6-byte timestamp sync link (controller and receiver).
package sync_pkg;
  localparam int TS_W       = 48;
  localparam int SYNC_BYTES = 6;

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_BYTE = 2'd1, RX_DROP = 2'd2} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;
endpackage

// File: rtl/sync_byte_serializer.sv
// Loads a 48-bit word and emits it as 6 MSB-first bytes; one request can queue behind the active frame.
module sync_byte_serializer
  import sync_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [TS_W-1:0] data,
  output logic [7:0]      byte_data,
  output logic            byte_wr,
  output logic            busy
);
  tx_state_t       state, state_nx;
  logic [TS_W-1:0] sh, sh_nx, pend_data, pend_data_nx, src;
  logic [2:0]      cnt, cnt_nx;
  logic            pend, pend_nx, wr_nx;
  logic [7:0]      dat_nx;

  // a request on the last-byte cycle is newer than anything pending
  assign src  = req ? data : pend_data;
  assign busy = (state == TX_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      sh        <= '0;
      pend_data <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      byte_data <= '0;
      byte_wr   <= 1'b0;
    end else begin
      state     <= state_nx;
      sh        <= sh_nx;
      pend_data <= pend_data_nx;
      cnt       <= cnt_nx;
      pend      <= pend_nx;
      byte_data <= dat_nx;
      byte_wr   <= wr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sh_nx        = sh;
    pend_data_nx = pend_data;
    cnt_nx       = cnt;
    pend_nx      = pend;
    dat_nx       = byte_data;
    wr_nx        = byte_wr;
    case (state)
      TX_IDLE: begin
        dat_nx = '0;
        wr_nx  = 1'b0;
        if (req) begin
          state_nx = TX_SEND;
          sh_nx    = data;
          cnt_nx   = '0;
        end
      end
      TX_SEND: begin
        if (cnt == 3'(SYNC_BYTES)) begin
          if (req || pend) begin
            dat_nx  = src[TS_W-1 -: 8];
            sh_nx   = {src[TS_W-9:0], 8'h00};
            wr_nx   = 1'b1;
            cnt_nx  = 3'd1;
            pend_nx = 1'b0;
          end else begin
            dat_nx   = '0;
            wr_nx    = 1'b0;
            cnt_nx   = '0;
            state_nx = TX_IDLE;
          end
        end else begin
          dat_nx = sh[TS_W-1 -: 8];
          sh_nx  = {sh[TS_W-9:0], 8'h00};
          wr_nx  = 1'b1;
          cnt_nx = cnt + 3'd1;
          if (req) begin
            pend_nx      = 1'b1;
            pend_data_nx = data;
          end
        end
      end
      default: state_nx = TX_IDLE;
    endcase
  end
endmodule

// File: rtl/sync_receive_module.sv
// Sync link receiver: deserializes sync frames, corrects the local clock, reports corrected time.
// Optional offset alarm output enabled by defining SRM_OFFSET_ALARM_EN.
module sync_receive_module
  import sync_pkg::*;
#(
  parameter logic [TS_W-1:0] TS_STEP = 48'd1,
  parameter logic [TS_W-1:0] RX_COMP = 48'd7
`ifdef SRM_OFFSET_ALARM_EN
  , parameter logic [TS_W-1:0] OFFSET_LIMIT = 48'd20000
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [7:0]      iv_sync_data,
  input  logic            i_sync_data_wr,
  output logic [TS_W-1:0] ov_local_ts,
  output logic            o_ts_sync_pulse,
  output logic [TS_W-1:0] ov_offset,
  output logic            o_offset_sign,
  output logic            o_frame_err,
  output logic [7:0]      ov_app_data,
  output logic            o_app_data_wr,
  output logic [3:0]      ov_srm_state
`ifdef SRM_OFFSET_ALARM_EN
  , output logic          o_offset_alarm
`endif
);
  rx_state_t       rx_state, rx_nx;
  logic [TS_W-1:0] rx_sh, rx_sh_nx, tgt, diff;
  logic [2:0]      rx_cnt, rx_cnt_nx;
  logic            frame_done, done_nx, err_nx, ahead, tx_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state    <= RX_IDLE;
      rx_sh       <= '0;
      rx_cnt      <= '0;
      frame_done  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_state    <= rx_nx;
      rx_sh       <= rx_sh_nx;
      rx_cnt      <= rx_cnt_nx;
      frame_done  <= done_nx;
      o_frame_err <= err_nx;
    end
  end

  always_comb begin
    rx_nx     = rx_state;
    rx_sh_nx  = rx_sh;
    rx_cnt_nx = rx_cnt;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    case (rx_state)
      RX_IDLE: if (i_sync_data_wr) begin
        rx_sh_nx  = {rx_sh[TS_W-9:0], iv_sync_data};
        rx_cnt_nx = 3'd1;
        rx_nx     = RX_BYTE;
      end
      RX_BYTE: if (i_sync_data_wr) begin
        rx_sh_nx  = {rx_sh[TS_W-9:0], iv_sync_data};
        rx_cnt_nx = rx_cnt + 3'd1;
        if (rx_cnt == 3'(SYNC_BYTES - 1)) begin
          done_nx = 1'b1;
          rx_nx   = RX_DROP;
        end
      end else begin
        err_nx    = 1'b1;
        rx_cnt_nx = '0;
        rx_nx     = RX_IDLE;
      end
      RX_DROP: if (!i_sync_data_wr) begin
        rx_cnt_nx = '0;
        rx_nx     = RX_IDLE;
      end
      default: rx_nx = RX_IDLE;
    endcase
  end

  // rx_sh is frozen in RX_DROP, so tgt is stable on the correction cycle
  assign tgt   = rx_sh + RX_COMP;
  assign ahead = ov_local_ts > tgt;
  assign diff  = ahead ? (ov_local_ts - tgt) : (tgt - ov_local_ts);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_local_ts     <= '0;
      ov_offset       <= '0;
      o_offset_sign   <= 1'b0;
      o_ts_sync_pulse <= 1'b0;
    end else begin
      o_ts_sync_pulse <= frame_done;
      if (frame_done) begin
        ov_local_ts   <= tgt;
        ov_offset     <= diff;
        o_offset_sign <= ahead;
      end else begin
        ov_local_ts   <= ov_local_ts + TS_STEP;
      end
    end
  end

`ifdef SRM_OFFSET_ALARM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        o_offset_alarm <= 1'b0;
    else if (frame_done) o_offset_alarm <= (diff > OFFSET_LIMIT);
  end
`endif

  sync_byte_serializer u_ser (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .req       (frame_done),
    .data      (tgt),
    .byte_data (ov_app_data),
    .byte_wr   (o_app_data_wr),
    .busy      (tx_busy)
  );

  assign ov_srm_state = {rx_state, 1'b0, tx_busy};
endmodule

// File: tb/tb_sync_receive_module.sv
// Directed bench for sync_receive_module: frame decode, correction, report framing, reset.
module tb_sync_receive_module;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  iv_sync_data = '0;
  logic        i_sync_data_wr = 1'b0;
  logic [47:0] ov_local_ts, ov_offset;
  logic        o_ts_sync_pulse, o_offset_sign, o_frame_err, o_app_data_wr;
  logic [7:0]  ov_app_data;
  logic [3:0]  ov_srm_state;
`ifdef SRM_OFFSET_ALARM_EN
  logic        o_offset_alarm;
`endif

  int checks = 0;
  int failures = 0;

  sync_receive_module dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .iv_sync_data    (iv_sync_data),
    .i_sync_data_wr  (i_sync_data_wr),
    .ov_local_ts     (ov_local_ts),
    .o_ts_sync_pulse (o_ts_sync_pulse),
    .ov_offset       (ov_offset),
    .o_offset_sign   (o_offset_sign),
    .o_frame_err     (o_frame_err),
    .ov_app_data     (ov_app_data),
    .o_app_data_wr   (o_app_data_wr),
    .ov_srm_state    (ov_srm_state)
`ifdef SRM_OFFSET_ALARM_EN
    , .o_offset_alarm (o_offset_alarm)
`endif
  );

  always #5 i_clk = ~i_clk;

  // report bytes, their cycle stamps and pulse counts, sampled on the falling edge
  int         cyc = 0;
  int         n_pulse = 0;
  int         n_err = 0;
  logic [7:0] rep_q[$];
  int         rep_cyc[$];
  always @(negedge i_clk) begin
    cyc++;
    if (o_app_data_wr) begin
      rep_q.push_back(ov_app_data);
      rep_cyc.push_back(cyc);
    end
    if (o_ts_sync_pulse) n_pulse++;
    if (o_frame_err) n_err++;
  end

  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_sync_data_wr = 1'b0;
    iv_sync_data = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic wait_ts(input logic [47:0] k);
    int n = 0;
    while (ov_local_ts !== k && n < 20000) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (ov_local_ts !== k) begin
      failures++;
      $display("FAIL wait_ts got=%h want=%h", ov_local_ts, k);
    end
  endtask

  // drives n contiguous bytes MSB-first, then one idle cycle; returns on the falling edge after it
  task automatic drive(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      i_sync_data_wr = 1'b1;
      iv_sync_data = d[8*(n-1-i) +: 8];
      @(negedge i_clk);
    end
    i_sync_data_wr = 1'b0;
    iv_sync_data = '0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({ov_local_ts, ov_offset, o_offset_sign, o_ts_sync_pulse, o_frame_err, ov_app_data, o_app_data_wr, ov_srm_state} !== '0) begin
      failures++;
      $display("FAIL reset_state ts=%h off=%h wr=%b st=%h want all 0", ov_local_ts, ov_offset, o_app_data_wr, ov_srm_state);
    end
  endtask

  task automatic test_basic_frame();
    logic [47:0] exp = 48'h0000_0000_1007;
    int base;
    apply_reset();
    wait_ts(48'h0FF9);
    base = rep_q.size();
    drive(64'h0000_0000_1000, 6);
    checks++;
    if (ov_local_ts !== 48'h1007) begin failures++; $display("FAIL basic_ts got=%h want=1007", ov_local_ts); end
    checks++;
    if (ov_offset !== 48'd8 || o_offset_sign !== 1'b0) begin
      failures++; $display("FAIL basic_offset got=%h/%b want=8/0", ov_offset, o_offset_sign);
    end
    checks++;
    if (o_ts_sync_pulse !== 1'b1) begin failures++; $display("FAIL basic_pulse got=%b want=1", o_ts_sync_pulse); end
    checks++;
    if (ov_srm_state !== 4'b0001) begin failures++; $display("FAIL basic_state got=%b want=0001", ov_srm_state); end
    repeat (10) @(negedge i_clk);
    checks++;
    if (rep_q.size() - base !== 6) begin
      failures++; $display("FAIL basic_report_len got=%0d want=6", rep_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rep_q[base+i] !== exp[47-8*i -: 8]) begin
          failures++; $display("FAIL basic_report_byte%0d got=%h want=%h", i, rep_q[base+i], exp[47-8*i -: 8]);
        end
      end
      checks++;
      if (rep_cyc[base+5] - rep_cyc[base] !== 5) begin
        failures++; $display("FAIL basic_report_contig span=%0d want=5", rep_cyc[base+5] - rep_cyc[base]);
      end
    end
  endtask

  task automatic test_runt();
    int base, p0, e0;
    apply_reset();
    wait_ts(48'h10);
    base = rep_q.size(); p0 = n_pulse; e0 = n_err;
    drive(64'h0000_0000_00AB_CDEF, 3);
    checks++;
    if (o_frame_err !== 1'b1) begin failures++; $display("FAIL runt_err got=%b want=1", o_frame_err); end
    checks++;
    if (ov_local_ts !== 48'h14) begin failures++; $display("FAIL runt_ts got=%h want=14", ov_local_ts); end
    repeat (11) @(negedge i_clk);
    checks++;
    if (ov_local_ts !== 48'h1F) begin failures++; $display("FAIL runt_ts_later got=%h want=1f", ov_local_ts); end
    checks++;
    if (n_err - e0 !== 1 || n_pulse - p0 !== 0 || rep_q.size() - base !== 0) begin
      failures++; $display("FAIL runt_counts err=%0d pulse=%0d rep=%0d want 1/0/0", n_err - e0, n_pulse - p0, rep_q.size() - base);
    end
  endtask

  task automatic test_overlong();
    logic [47:0] exp = 48'h0000_0001_0007;
    int base, p0, e0;
    apply_reset();
    wait_ts(48'h10);
    base = rep_q.size(); p0 = n_pulse; e0 = n_err;
    drive(64'h0000_0001_0000_AABB, 8);
    checks++;
    if (ov_local_ts !== 48'h1_0009) begin failures++; $display("FAIL long_ts got=%h want=10009", ov_local_ts); end
    checks++;
    if (ov_offset !== 48'hFFF1 || o_offset_sign !== 1'b0) begin
      failures++; $display("FAIL long_offset got=%h/%b want=fff1/0", ov_offset, o_offset_sign);
    end
    repeat (10) @(negedge i_clk);
    checks++;
    if (n_pulse - p0 !== 1 || n_err - e0 !== 0) begin
      failures++; $display("FAIL long_counts pulse=%0d err=%0d want 1/0", n_pulse - p0, n_err - e0);
    end
    checks++;
    if (rep_q.size() - base !== 6) begin
      failures++; $display("FAIL long_report_len got=%0d want=6", rep_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rep_q[base+i] !== exp[47-8*i -: 8]) begin
          failures++; $display("FAIL long_report_byte%0d got=%h want=%h", i, rep_q[base+i], exp[47-8*i -: 8]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    wait_ts(48'h10);
    drive(64'hFFFF_FFFF_FFFC, 6);
    checks++;
    if (ov_local_ts !== 48'h3) begin failures++; $display("FAIL wrap_ts got=%h want=3", ov_local_ts); end
    checks++;
    if (ov_offset !== 48'h13 || o_offset_sign !== 1'b1) begin
      failures++; $display("FAIL wrap_offset got=%h/%b want=13/1", ov_offset, o_offset_sign);
    end
    @(negedge i_clk);
    checks++;
    if (ov_local_ts !== 48'h4) begin failures++; $display("FAIL wrap_next got=%h want=4", ov_local_ts); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp = 96'h0000_0000_0107_0000_0000_0207;
    int base;
    apply_reset();
    wait_ts(48'h20);
    base = rep_q.size();
    drive(64'h0000_0000_0100, 6);
    checks++;
    if (ov_local_ts !== 48'h107 || ov_offset !== 48'hE1) begin
      failures++; $display("FAIL b2b_first ts=%h off=%h want 107/e1", ov_local_ts, ov_offset);
    end
    drive(64'h0000_0000_0200, 6);
    checks++;
    if (ov_local_ts !== 48'h207 || ov_offset !== 48'hFA || o_offset_sign !== 1'b0) begin
      failures++; $display("FAIL b2b_second ts=%h off=%h sign=%b want 207/fa/0", ov_local_ts, ov_offset, o_offset_sign);
    end
    repeat (14) @(negedge i_clk);
    checks++;
    if (rep_q.size() - base !== 12) begin
      failures++; $display("FAIL b2b_report_len got=%0d want=12", rep_q.size() - base);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (rep_q[base+i] !== exp[95-8*i -: 8]) begin
          failures++; $display("FAIL b2b_byte%0d got=%h want=%h", i, rep_q[base+i], exp[95-8*i -: 8]);
        end
      end
      checks++;
      if (rep_cyc[base+11] - rep_cyc[base] !== 11) begin
        failures++; $display("FAIL b2b_contig span=%0d want=11", rep_cyc[base+11] - rep_cyc[base]);
      end
    end
  endtask

  task automatic test_async_reset();
    int base, p0;
    apply_reset();
    wait_ts(48'h10);
    drive(64'h0000_0000_1000, 6);
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_app_data_wr !== 1'b1) begin failures++; $display("FAIL areset_midtx wr=%b want=1", o_app_data_wr); end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({ov_local_ts, ov_offset, o_offset_sign, o_ts_sync_pulse, o_frame_err, ov_app_data, o_app_data_wr, ov_srm_state} !== '0) begin
      failures++; $display("FAIL areset_outputs ts=%h off=%h data=%h wr=%b st=%h want all 0", ov_local_ts, ov_offset, ov_app_data, o_app_data_wr, ov_srm_state);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    base = rep_q.size(); p0 = n_pulse;
    repeat (10) @(negedge i_clk);
    checks++;
    if (rep_q.size() - base !== 0 || n_pulse - p0 !== 0 || ov_local_ts !== 48'd10) begin
      failures++; $display("FAIL areset_after rep=%0d pulse=%0d ts=%h want 0/0/a", rep_q.size() - base, n_pulse - p0, ov_local_ts);
    end
  endtask

`ifdef SRM_OFFSET_ALARM_EN
  task automatic test_alarm();
    apply_reset();
    wait_ts(48'h10);
    drive(64'd20016, 6);
    checks++;
    if (ov_offset !== 48'd20001 || o_offset_alarm !== 1'b1) begin
      failures++; $display("FAIL alarm_set off=%0d alarm=%b want 20001/1", ov_offset, o_offset_alarm);
    end
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_offset_alarm !== 1'b1) begin failures++; $display("FAIL alarm_hold got=%b want=1", o_offset_alarm); end
    apply_reset();
    wait_ts(48'h10);
    drive(64'd20016, 6);
    drive(64'd40022, 6);
    checks++;
    if (ov_offset !== 48'd20000 || o_offset_alarm !== 1'b0) begin
      failures++; $display("FAIL alarm_clear off=%0d alarm=%b want 20000/0", ov_offset, o_offset_alarm);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_runt();
    test_overlong();
    test_wrap();
    test_back_to_back();
    test_async_reset();
`ifdef SRM_OFFSET_ALARM_EN
    test_alarm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
